cla_seq_adder: RTL and testbench

Multi-byte add sequencer that reuses one CLA8 (8-bit carry-lookahead adder) as its only arithmetic datapath. It computes an NBYTES×8-bit sum one byte per cycle, least-significant byte first, and registers the inter-byte carry between cycles. It sits between an operand producer and a result consumer, with a valid/ready handshake on each side. This lets wide additions share the existing narrow adder instead of instantiating a wide one.

---
 rtl/cla_seq_adder.sv | 157 +++++++++++++++
 tb/tb_cla_seq_adder.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/cla_seq_adder.sv
// cla_seq_adder: multi-byte adder that time-shares a single 8-bit carry-lookahead
// adder, one byte per cycle, LSB first, with a registered inter-byte carry.
// Optional feature macro: CLASEQ_SUB_EN adds the 'sub' port (A - B via ~B + 1).
module cla_seq_adder #(
  parameter int unsigned NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_valid,
  output logic                  start_ready,
  input  logic [8*NBYTES-1:0]   a_in,
  input  logic [8*NBYTES-1:0]   b_in,
  input  logic                  cin,
`ifdef CLASEQ_SUB_EN
  input  logic                  sub,
`endif
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [8*NBYTES-1:0]   sum,
  output logic                  cout,
  output logic                  ovf,
  output logic                  busy
);

  localparam int unsigned W    = 8 * NBYTES;
  localparam int unsigned IdxW = $clog2(NBYTES);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(NBYTES - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic            carry_q, carry_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    sum_q, sum_d;
  logic            cout_q, cout_d;
  logic            ovf_q, ovf_d;

  // Operand/carry values captured on accept; subtraction stores ~B and forces carry-in to 1.
  logic         sub_op;
  logic [W-1:0] b_load;
  logic         carry_load;

`ifdef CLASEQ_SUB_EN
  assign sub_op = sub;
`else
  assign sub_op = 1'b0;
`endif

  assign b_load     = sub_op ? ~b_in : b_in;
  assign carry_load = sub_op ? 1'b1 : cin;

  // Byte slice feeding the shared CLA8 this cycle.
  logic [7:0] byte_a, byte_b;
  assign byte_a = a_q[8*idx_q +: 8];
  assign byte_b = b_q[8*idx_q +: 8];

  logic [7:0] cla_g, cla_p;
  logic [8:0] cla_c;
  logic [8:0] cla_sum;
  logic       cla_acc, cla_prop;

  // CLA8: every carry is formed directly from generate/propagate terms and the carry-in.
  always_comb begin
    cla_g    = byte_a & byte_b;
    cla_p    = byte_a ^ byte_b;
    cla_c    = '0;
    cla_acc  = 1'b0;
    cla_prop = 1'b1;
    cla_c[0] = carry_q;
    for (int i = 1; i <= 8; i++) begin
      cla_acc  = 1'b0;
      cla_prop = 1'b1;
      for (int j = i - 1; j >= 0; j--) begin
        cla_acc  = cla_acc | (cla_prop & cla_g[j]);
        cla_prop = cla_prop & cla_p[j];
      end
      cla_c[i] = cla_acc | (cla_prop & carry_q);
    end
    cla_sum = {cla_c[8], cla_p ^ cla_c[7:0]};
  end

  // Next-state and datapath update for the IDLE -> RUN -> DONE sequence.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (start_valid) begin
          a_d     = a_in;
          b_d     = b_load;
          carry_d = carry_load;
          idx_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        sum_d[8*idx_q +: 8] = cla_sum[7:0];
        carry_d             = cla_sum[8];
        if (idx_q == IdxLast) begin
          cout_d  = cla_sum[8];
          ovf_d   = (byte_a[7] == byte_b[7]) & (cla_sum[7] != byte_a[7]);
          // Park the index at 0 so it never passes NBYTES-1.
          idx_d   = '0;
          state_d = StDone;
        end else begin
          idx_d = idx_q + IdxW'(1);
        end
      end
      StDone: begin
        if (res_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous active-low reset; handshake flags registered from state_d.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      start_ready <= 1'b1;
      busy        <= 1'b0;
      res_valid   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      start_ready <= (state_d == StIdle);
      busy        <= (state_d == StRun);
      res_valid   <= (state_d == StDone);
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_cla_seq_adder.sv
// Directed self-checking bench for cla_seq_adder (NBYTES=4).
module tb_cla_seq_adder;

  localparam int unsigned NBYTES = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_valid = 1'b0;
  logic        start_ready;
  logic [31:0] a_in = '0;
  logic [31:0] b_in = '0;
  logic        cin = 1'b0;
  logic        sub = 1'b0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [31:0] sum;
  logic        cout;
  logic        ovf;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  cla_seq_adder #(.NBYTES(NBYTES)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_valid(start_valid),
    .start_ready(start_ready),
    .a_in       (a_in),
    .b_in       (b_in),
    .cin        (cin),
`ifdef CLASEQ_SUB_EN
    .sub        (sub),
`endif
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .sum        (sum),
    .cout       (cout),
    .ovf        (ovf),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      $error("check %s differs", tag);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation and wait for res_valid; returns cycles to result and busy cycles seen.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic ci,
                        input logic sb, output int cycles, output int busy_cnt);
    int w;
    w = 0;
    while (!start_ready && w < 20) begin
      tick();
      w++;
    end
    a_in        = a;
    b_in        = b;
    cin         = ci;
    sub         = sb;
    start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    // Scramble inputs after acceptance; they must not matter.
    a_in = ~a;
    b_in = ~b;
    cin  = ~ci;
    sub  = ~sb;
    cycles   = 0;
    busy_cnt = 0;
    while (!res_valid && cycles < 40) begin
      if (busy) busy_cnt++;
      tick();
      cycles++;
    end
  endtask

  task automatic consume();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  task automatic check_res(input string tag, input logic [31:0] es, input logic ec,
                           input logic eo);
    check({tag, ".valid"}, 64'(res_valid), 64'(1));
    check({tag, ".sum"},   64'(sum),       64'(es));
    check({tag, ".cout"},  64'(cout),      64'(ec));
    check({tag, ".ovf"},   64'(ovf),       64'(eo));
  endtask

  initial begin
    int cyc;
    int bcnt;

    // Reset values
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    check("rst.start_ready", 64'(start_ready), 64'(1));
    check("rst.busy",        64'(busy),        64'(0));
    check("rst.res_valid",   64'(res_valid),   64'(0));
    check("rst.sum",         64'(sum),         64'(0));
    check("rst.cout",        64'(cout),        64'(0));
    check("rst.ovf",         64'(ovf),         64'(0));

    // Basic add with latency and busy length
    run_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, cyc, bcnt);
    check("add1.latency", 64'(cyc), 64'(4));
    check("add1.busy_cycles", 64'(bcnt), 64'(4));
    check("add1.busy_done", 64'(busy), 64'(0));
    check("add1.start_ready_done", 64'(start_ready), 64'(0));
    check_res("add1", 32'h0000_0100, 1'b0, 1'b0);
    consume();
    check("add1.valid_clear", 64'(res_valid), 64'(0));
    check("add1.start_ready_after", 64'(start_ready), 64'(1));

    // Full carry ripple
    run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, cyc, bcnt);
    check("ripple1.latency", 64'(cyc), 64'(4));
    check_res("ripple1", 32'h0000_0000, 1'b1, 1'b0);
    consume();
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, cyc, bcnt);
    check_res("ripple2", 32'hFFFF_FFFF, 1'b1, 1'b0);
    consume();

    // Signed overflow
    run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, cyc, bcnt);
    check_res("ovf", 32'h8000_0000, 1'b0, 1'b1);
    consume();

    // Backpressure in DONE with a competing start request
    run_op(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, cyc, bcnt);
    check_res("bp.first", 32'h2345_6789, 1'b0, 1'b0);
    a_in        = 32'h0000_0001;
    b_in        = 32'h0000_0001;
    start_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check_res("bp.hold", 32'h2345_6789, 1'b0, 1'b0);
      check("bp.start_ready", 64'(start_ready), 64'(0));
      check("bp.busy", 64'(busy), 64'(0));
    end
    start_valid = 1'b0;
    consume();
    check("bp.valid_clear", 64'(res_valid), 64'(0));
    check("bp.start_ready_after", 64'(start_ready), 64'(1));
    check("bp.sum_kept", 64'(sum), 64'(32'h2345_6789));
    check("bp.not_taken", 64'(busy), 64'(0));

    // res_ready held high before res_valid rises
    res_ready = 1'b1;
    run_op(32'h0001_0000, 32'h0000_FFFF, 1'b0, 1'b0, cyc, bcnt);
    check("early_ready.latency", 64'(cyc), 64'(4));
    check_res("early_ready", 32'h0001_FFFF, 1'b0, 1'b0);
    tick();
    res_ready = 1'b0;
    check("early_ready.valid_clear", 64'(res_valid), 64'(0));

    // Reset during the 2nd RUN cycle
    a_in        = 32'hFFFF_FFFF;
    b_in        = 32'hFFFF_FFFF;
    cin         = 1'b1;
    sub         = 1'b0;
    start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    tick();
    check("midrst.busy_before", 64'(busy), 64'(1));
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst.start_ready", 64'(start_ready), 64'(1));
    check("midrst.busy",        64'(busy),        64'(0));
    check("midrst.res_valid",   64'(res_valid),   64'(0));
    check("midrst.sum",         64'(sum),         64'(0));
    check("midrst.cout",        64'(cout),        64'(0));
    check("midrst.ovf",         64'(ovf),         64'(0));
    run_op(32'd10, 32'd5, 1'b0, 1'b0, cyc, bcnt);
    check("midrst.after_latency", 64'(cyc), 64'(4));
    check_res("midrst.after", 32'd15, 1'b0, 1'b0);
    consume();

`ifdef CLASEQ_SUB_EN
    // Subtraction: cin ignored, cout=1 means no borrow
    run_op(32'd5, 32'd7, 1'b1, 1'b1, cyc, bcnt);
    check("sub1.latency", 64'(cyc), 64'(4));
    check_res("sub1", 32'hFFFF_FFFE, 1'b0, 1'b0);
    consume();
    run_op(32'h8000_0000, 32'd1, 1'b0, 1'b1, cyc, bcnt);
    check_res("sub2", 32'h7FFF_FFFF, 1'b1, 1'b1);
    consume();
    run_op(32'd9, 32'd4, 1'b0, 1'b0, cyc, bcnt);
    check_res("sub_off", 32'd13, 1'b0, 1'b0);
    consume();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
